// File: rtl/cla_pkg.sv
// Shared constants and helpers for the carry-lookahead adder.
package cla_pkg;

  localparam int GROUP_W = 4;

  function automatic int num_groups(input int width);
    return width / GROUP_W;
  endfunction

  function automatic bit width_ok(input int width);
    return (width > 0) && (width % GROUP_W == 0);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit lookahead group: local carries, sum bits, and group
// generate/propagate for the second-level unit.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               c_in,
  output logic [GROUP_W-1:0] s,
  output logic               gg,
  output logic               gp
);

  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = c_in;
  assign c[1] = g[0]
              | (p[0] & c_in);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c_in);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);

  assign s = p ^ c;

  // gg/gp depend only on a/b, never on c_in
  assign gg = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;

endmodule

// File: rtl/cla_adder_4b.sv
// Registered carry-lookahead adder: {cout,sum} <= a + b + cin,
// built from 4-bit groups and a flat second-level carry unit.
module cla_adder_4b
  import cla_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NG = num_groups(WIDTH);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $fatal(1, "WIDTH must be a positive multiple of 4");
  end

  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   res_d;
  logic [WIDTH:0]   res_q;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_grp (
      .a    (a[k*GROUP_W +: GROUP_W]),
      .b    (b[k*GROUP_W +: GROUP_W]),
      .c_in (gc[k]),
      .s    (s[k*GROUP_W +: GROUP_W]),
      .gg   (gg[k]),
      .gp   (gp[k])
    );
  end

  // Sum-of-products per group carry, no group-level ripple
  always_comb begin
    logic term;
    term  = 1'b0;
    gc    = '0;
    gc[0] = cin;
    for (int k = 1; k <= NG; k++) begin
      term = cin;
      for (int m = 0; m < k; m++) begin
        term = term & gp[m];
      end
      gc[k] = term;
      for (int j = 0; j < k; j++) begin
        term = gg[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & gp[m];
        end
        gc[k] = gc[k] | term;
      end
    end
  end

  assign res_d = {gc[NG], s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign sum  = res_q[WIDTH-1:0];
  assign cout = res_q[WIDTH];

endmodule

// File: tb/tb_cla_adder_4b.sv
// Scoreboard bench for cla_adder_4b at WIDTH 4, 8 and 16.
module tb_cla_adder_4b;

  logic        clk = 1'b0;
  logic        rst;
  logic        cin;
  logic [3:0]  a4, b4, s4;
  logic [7:0]  a8, b8, s8;
  logic [15:0] a16, b16, s16;
  logic        co4, co8, co16;

  int n_chk  = 0;
  int n_fail = 0;

  logic [16:0] q4[$];
  logic [16:0] q8[$];
  logic [16:0] q16[$];

  always #5 clk = ~clk;

  cla_adder_4b #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4),
    .cin(cin), .sum(s4), .cout(co4)
  );

  cla_adder_4b #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8),
    .cin(cin), .sum(s8), .cout(co8)
  );

  cla_adder_4b #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16),
    .cin(cin), .sum(s16), .cout(co16)
  );

  task automatic check(
    input string       nm,
    input logic [16:0] act,
    input logic [16:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive_all(
    input logic [3:0]  x,
    input logic [3:0]  y,
    input logic        c,
    input logic [4:0]  e,
    input logic [7:0]  x8,
    input logic [7:0]  y8,
    input logic [15:0] x16,
    input logic [15:0] y16
  );
    @(negedge clk);
    a4  = x;   b4  = y;   cin = c;
    a8  = x8;  b8  = y8;
    a16 = x16; b16 = y16;
    q4.push_back({12'h0, e});
    q8.push_back(17'(x8) + 17'(y8) + 17'(c));
    q16.push_back(17'(x16) + 17'(y16) + 17'(c));
  endtask

  task automatic apply(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       c,
    input logic [4:0] e
  );
    drive_all(x, y, c, e,
              8'($urandom), 8'($urandom),
              16'($urandom), 16'($urandom));
  endtask

  // Monitor: every edge taken with rst low presents a result
  always @(posedge clk) begin
    logic [16:0] e;
    #1;
    if (!rst) begin
      if (q4.size() > 0) begin
        e = q4.pop_front();
        check("sb_w4", {12'h0, co4, s4}, e);
      end
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check("sb_w8", {8'h0, co8, s8}, e);
      end
      if (q16.size() > 0) begin
        e = q16.pop_front();
        check("sb_w16", {co16, s16}, e);
      end
    end
  end

  initial begin
    logic [8:0] v;
    rst = 1'b1;
    a4  = 4'($urandom);  b4  = 4'($urandom);
    a8  = 8'($urandom);  b8  = 8'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom);
    cin = 1'($urandom);
    #20;
    check("rst_w4", {12'h0, co4, s4}, 17'h0);
    check("rst_w16", {co16, s16}, 17'h0);
    a4 = 4'hF; b4 = 4'hF; cin = 1'b1;
    @(posedge clk); #1;
    check("rst_hold", {12'h0, co4, s4}, 17'h0);
    @(negedge clk);
    rst = 1'b0;

    apply(4'hF, 4'hF, 1'b1, 5'h1F);
    apply(4'hF, 4'h0, 1'b1, 5'h10);
    apply(4'hF, 4'h0, 1'b0, 5'h0F);
    apply(4'h9, 4'h6, 1'b1, 5'h10);
    apply(4'h5, 4'h3, 1'b0, 5'h08);

    // operands change mid-cycle; output must hold
    @(posedge clk); #2;
    a4 = 4'h1; b4 = 4'h2; cin = 1'b0;
    #1;
    check("hold_a", {12'h0, co4, s4}, 17'h08);
    #4;
    check("hold_b", {12'h0, co4, s4}, 17'h08);
    q4.push_back(17'h03);

    apply(4'h7, 4'h8, 1'b1, 5'h10);
    apply(4'hC, 4'h3, 1'b0, 5'h0F);
    apply(4'h6, 4'h4, 1'b0, 5'h0A);

    // async reset between edges
    @(posedge clk); #3;
    check("pre_rst", {12'h0, co4, s4}, 17'h0A);
    rst = 1'b1;
    #1;
    check("async_w4", {12'h0, co4, s4}, 17'h0);
    check("async_w16", {co16, s16}, 17'h0);
    a4 = 4'h7; b4 = 4'h7; cin = 1'b0;
    @(posedge clk); #1;
    check("in_rst", {12'h0, co4, s4}, 17'h0);
    @(negedge clk);
    rst = 1'b0;
    a4 = 4'h2; b4 = 4'h1; cin = 1'b0;
    q4.push_back(17'h03);

    for (int i = 0; i < 512; i++) begin
      v = i[8:0];
      apply(v[3:0], v[7:4], v[8],
            5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]));
    end

    drive_all(4'h0, 4'h0, 1'b1, 5'h01,
              8'hFF, 8'h00, 16'hFFFF, 16'h0000);
    drive_all(4'hF, 4'h1, 1'b0, 5'h10,
              8'h80, 8'h80, 16'h8000, 16'h8000);
    drive_all(4'h0, 4'h0, 1'b0, 5'h00,
              8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF);
    drive_all(4'hA, 4'h5, 1'b1, 5'h10,
              8'h0F, 8'hF0, 16'h0FFF, 16'hF000);

    @(posedge clk);
    @(posedge clk); #2;
    check("drain",
          17'(q4.size() + q8.size() + q16.size()),
          17'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
